alu_mp_seq: RTL and testbench

- Multi-precision sequencer for the shared N-bit ALU.
- Accepts one WORDS×N-bit operation (add, sub, and, or), then drives the ALU one word per cycle, least-significant word first.
- Chains the carry/borrow between words and assembles the wide result.
- Sits between the control unit and the ALU. The ALU is external so other masters can share it when this block is idle.

---
 rtl/alu_mp_seq_pkg.sv | 32 +++
 rtl/alu_mp_seq_if.sv | 40 ++++
 rtl/alu_mp_wsel.sv | 17 +
 rtl/alu_mp_seq.sv | 116 +++++++++++
 tb/tb_alu_mp_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_mp_seq_pkg.sv
// Shared encodings for the multi-precision ALU sequencer: op codes, FSM states, ALU opcodes.
// op_legal() admits the compare op only when ALU_MP_SEQ_CMP_EN is defined.
package alu_mp_seq_pkg;

   localparam int OP_W = 3;
   localparam logic [OP_W-1:0] SEQ_OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] SEQ_OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] SEQ_OP_AND = 3'b010;
   localparam logic [OP_W-1:0] SEQ_OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] SEQ_OP_CMP = 3'b100;

   localparam int AC_N = 4;
   localparam logic [AC_N-1:0] AC_AD = 4'h0;
   localparam logic [AC_N-1:0] AC_SB = 4'h1;
   localparam logic [AC_N-1:0] AC_AN = 4'h2;
   localparam logic [AC_N-1:0] AC_OR = 4'h3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   function automatic logic op_legal(input logic [OP_W-1:0] op);
`ifdef ALU_MP_SEQ_CMP_EN
      return (op <= SEQ_OP_CMP);
`else
      return (op <= SEQ_OP_OR);
`endif
   endfunction

endpackage

// File: rtl/alu_mp_seq_if.sv
// Control-unit request/response bus plus the word-serial ALU port of the sequencer.
interface alu_mp_seq_if
   import alu_mp_seq_pkg::*;
#(
   parameter int N     = 8,
   parameter int WORDS = 4
) ();

   logic                 start;
   logic [OP_W-1:0]      op;
   logic [N*WORDS-1:0]   a_in;
   logic [N*WORDS-1:0]   b_in;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [N*WORDS-1:0]   result;
   logic                 carry;
   logic                 zero;

   logic [AC_N-1:0]      alu_cs;
   logic [N-1:0]         alu_a;
   logic [N-1:0]         alu_b;
   logic                 alu_cin;
   logic [N-1:0]         alu_s;
   logic                 alu_zero;
   logic                 alu_cout;

   modport master (
      output start, op, a_in, b_in, alu_s, alu_zero, alu_cout,
      input  ready, busy, done, result, carry, zero,
             alu_cs, alu_a, alu_b, alu_cin
   );

   modport slave (
      input  start, op, a_in, b_in, alu_s, alu_zero, alu_cout,
      output ready, busy, done, result, carry, zero,
             alu_cs, alu_a, alu_b, alu_cin
   );

endinterface

// File: rtl/alu_mp_wsel.sv
// Word-select mux: picks N-bit word idx out of a WORDS*N-bit operand.
module alu_mp_wsel #(
   parameter int N     = 8,
   parameter int WORDS = 4,
   parameter int IW    = 2
) (
   input  logic [N*WORDS-1:0] wide,
   input  logic [IW-1:0]      idx,
   output logic [N-1:0]       word
);

   logic [WORDS-1:0][N-1:0] words;

   assign words = wide;
   assign word  = words[idx];

endmodule

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: runs one WORDS*N-bit op through the external N-bit ALU, LSW first.
// Optional compare op (result untouched, carry = A<B, zero = A==B) enabled by ALU_MP_SEQ_CMP_EN.
module alu_mp_seq
   import alu_mp_seq_pkg::*;
#(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   alu_mp_seq_if.slave   bus
);

   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int W  = N * WORDS;

   seq_state_e       state_q, state_d;
   logic [IW-1:0]    idx_q;
   logic [W-1:0]     a_q, b_q, result_q;
   logic [OP_W-1:0]  op_q;
   logic             chain_q, zacc_q, carry_q, zero_q;
   logic             accept, last_word, is_sub, is_logic, wr_result;
   logic [N-1:0]     word_a, word_b;

   assign accept    = (state_q == IDLE) && bus.start && op_legal(bus.op);
   assign last_word = (idx_q == IW'(WORDS - 1));
   assign is_logic  = (op_q == SEQ_OP_AND) || (op_q == SEQ_OP_OR);
`ifdef ALU_MP_SEQ_CMP_EN
   assign is_sub    = (op_q == SEQ_OP_SUB) || (op_q == SEQ_OP_CMP);
   assign wr_result = (op_q != SEQ_OP_CMP);
`else
   assign is_sub    = (op_q == SEQ_OP_SUB);
   assign wr_result = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: combinational blocks assign a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last_word) state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready   = (state_q == IDLE);
      bus.busy    = (state_q == RUN);
      bus.done    = (state_q == DONE);
      bus.alu_cs  = AC_AN;
      bus.alu_cin = 1'b0;
      if (state_q == RUN) begin
         case (op_q)
            SEQ_OP_ADD: begin
               bus.alu_cs  = AC_AD;
               bus.alu_cin = (idx_q == '0) ? 1'b0 : chain_q;
            end
            SEQ_OP_OR:  bus.alu_cs = AC_OR;
            SEQ_OP_AND: bus.alu_cs = AC_AN;
            default: if (is_sub) begin
               // ALU reports borrow on alu_cout, so the next word's carry-in is its inverse.
               bus.alu_cs  = AC_SB;
               bus.alu_cin = (idx_q == '0) ? 1'b1 : ~chain_q;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         chain_q  <= 1'b0;
         zacc_q   <= 1'b1;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
      end else if (accept) begin
         a_q     <= bus.a_in;
         b_q     <= bus.b_in;
         op_q    <= bus.op;
         idx_q   <= '0;
         zacc_q  <= 1'b1;
         chain_q <= 1'b0;
      end else if (state_q == RUN) begin
         if (wr_result) result_q[int'(idx_q)*N +: N] <= bus.alu_s;
         chain_q <= bus.alu_cout;
         zacc_q  <= zacc_q & bus.alu_zero;
         idx_q   <= idx_q + IW'(1);
         if (last_word) begin
            idx_q   <= '0;
            carry_q <= is_logic ? 1'b0 : bus.alu_cout;
            zero_q  <= zacc_q & bus.alu_zero;
         end
      end
   end

   alu_mp_wsel #(.N(N), .WORDS(WORDS), .IW(IW)) u_wsel_a (.wide(a_q), .idx(idx_q), .word(word_a));
   alu_mp_wsel #(.N(N), .WORDS(WORDS), .IW(IW)) u_wsel_b (.wide(b_q), .idx(idx_q), .word(word_b));

   assign bus.alu_a  = word_a;
   assign bus.alu_b  = word_b;
   assign bus.result = result_q;
   assign bus.carry  = carry_q;
   assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq (N=8, WORDS=4) with a behavioural 8-bit ALU attached.
module tb_alu_mp_seq;
   import alu_mp_seq_pkg::*;

   localparam int N     = 8;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   alu_mp_seq_if #(.N(N), .WORDS(WORDS)) bus ();
   alu_mp_seq #(.N(N), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   // External ALU: sub computes a + ~b + cin and reports borrow (= ~carry) on alu_cout.
   logic [N:0] alu_t;
   always_comb begin
      alu_t = '0;
      case (bus.alu_cs)
         AC_AD:   alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + (N+1)'(bus.alu_cin);
         AC_SB:   begin
            alu_t    = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + (N+1)'(bus.alu_cin);
            alu_t[N] = ~alu_t[N];
         end
         AC_AN:   alu_t = {1'b0, bus.alu_a & bus.alu_b};
         AC_OR:   alu_t = {1'b0, bus.alu_a | bus.alu_b};
         default: alu_t = '0;
      endcase
      bus.alu_s    = alu_t[N-1:0];
      bus.alu_cout = alu_t[N];
      bus.alu_zero = (alu_t[N-1:0] == '0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: whole-width arithmetic; compare leaves the previous result in place.
   logic [W-1:0] model_prev = '0;
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic c, output logic z);
      logic [W:0] wide;
      c = 1'b0;
      case (op)
         SEQ_OP_ADD: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
         SEQ_OP_SUB: begin r = a - b; c = (a < b); end
         SEQ_OP_AND: r = a & b;
         SEQ_OP_OR:  r = a | b;
         default:    r = model_prev;
      endcase
      z = (r == '0);
      if (op == SEQ_OP_CMP) begin c = (a < b); z = (a == b); end
      model_prev = r;
   endtask

   logic [WORDS-1:0] cin_bits;

   // Presents one op at an IDLE cycle; lat = edges from accept edge until done is seen.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      int k;
      bus.op = op; bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0; k = 0; cin_bits = '0;
      while (!bus.done && lat < 40) begin
         if (bus.busy && k < WORDS) begin cin_bits[k] = bus.alu_cin; k++; end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   typedef struct {
      string          name;
      logic [2:0]     op;
      logic [W-1:0]   a, b, res;
      logic           c, z;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int lat, seen;
      logic [W-1:0] er, ra, rb;
      logic ec, ez;
      logic [2:0] rop;

      vecs[0] = '{"add_carry_word", SEQ_OP_ADD, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0};
      vecs[1] = '{"add_wrap",       SEQ_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
      vecs[2] = '{"sub_underflow",  SEQ_OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[3] = '{"sub_equal",      SEQ_OP_SUB, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};
      vecs[4] = '{"and",            SEQ_OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0};
      vecs[5] = '{"or",             SEQ_OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0};

      bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;
      repeat (2) @(posedge clk);
      #1 check("reset_ready", bus.ready, 1'b1);
      check("reset_busy",   bus.busy, 1'b0);
      check("reset_done",   bus.done, 1'b0);
      check("reset_result", bus.result, '0);
      check("reset_carry",  bus.carry, 1'b0);
      check("reset_zero",   bus.zero, 1'b1);
      check("reset_alu_cs", bus.alu_cs, AC_AN);
      check("reset_alu_cin", bus.alu_cin, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         model(vecs[i].op, vecs[i].a, vecs[i].b, er, ec, ez);
         check({vecs[i].name, "_model"}, er, vecs[i].res);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         // Done lands in cycle WORDS+1 counting the start cycle as 0, i.e. WORDS edges after accept.
         check({vecs[i].name, "_latency"}, lat, WORDS);
         check({vecs[i].name, "_result"}, bus.result, vecs[i].res);
         check({vecs[i].name, "_carry"}, bus.carry, vecs[i].c);
         check({vecs[i].name, "_zero"}, bus.zero, vecs[i].z);
         if (i == 1) check("add_wrap_cin", cin_bits, 4'b1110);
         if (i == 2) check("sub_underflow_cin", cin_bits, 4'b0001);
         @(posedge clk); #1;
         check({vecs[i].name, "_ready_after"}, bus.ready, 1'b1);
      end

      // start with new operands while RUN must be ignored and not queued
      bus.op = SEQ_OP_ADD; bus.a_in = 32'h1; bus.b_in = 32'h2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.a_in = 32'hFFFF_FFFF; bus.b_in = 32'h5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
      check("busy_start_result", bus.result, 32'h3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy_start_not_queued", bus.busy, 1'b0);
      model_prev = 32'h3;

      // reset in the second RUN cycle aborts the op
      bus.op = SEQ_OP_ADD; bus.a_in = 32'h00FF_FFFF; bus.b_in = 32'h1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      check("rst_mid_ready",  bus.ready, 1'b1);
      check("rst_mid_busy",   bus.busy, 1'b0);
      check("rst_mid_result", bus.result, '0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (bus.done) seen++; end
      check("rst_mid_no_done", seen, 0);
      model_prev = '0;

      // illegal op code is ignored
      bus.op = 3'b101; bus.a_in = 32'h7; bus.b_in = 32'h9; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("illegal_ready", bus.ready, 1'b1);
      check("illegal_busy",  bus.busy, 1'b0);

`ifdef ALU_MP_SEQ_CMP_EN
      run_op(SEQ_OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
      model(SEQ_OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, er, ec, ez);
      @(posedge clk); #1;
      run_op(SEQ_OP_CMP, 32'h5, 32'h7, lat);
      model(SEQ_OP_CMP, 32'h5, 32'h7, er, ec, ez);
      check("cmp_latency", lat, WORDS);
      check("cmp_carry",  bus.carry, 1'b1);
      check("cmp_zero",   bus.zero, 1'b0);
      check("cmp_result_held", bus.result, 32'hFFF0_FF34);
      @(posedge clk); #1;
`else
      bus.op = SEQ_OP_CMP; bus.a_in = 32'h5; bus.b_in = 32'h7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("cmp_off_ready", bus.ready, 1'b1);
      check("cmp_off_busy",  bus.busy, 1'b0);
`endif

      // randomized ops against the whole-width model
      for (int i = 0; i < 40; i++) begin
`ifdef ALU_MP_SEQ_CMP_EN
         rop = 3'($urandom_range(0, 4));
`else
         rop = 3'($urandom_range(0, 3));
`endif
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
         model(rop, ra, rb, er, ec, ez);
         run_op(rop, ra, rb, lat);
         check("rand_latency", lat, WORDS);
         check("rand_result", bus.result, er);
         check("rand_carry",  bus.carry, ec);
         check("rand_zero",   bus.zero, ez);
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
